// File: rtl/fifo_uart_tx_if.sv
// Bundle between the FIFO read port, the 8N1 serialiser and the UART pin.
// master: serialiser side; slave: FIFO/pin side.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              tx_en;
  logic              empty;
  logic [DATA_W-1:0] fifo_data;
  logic              rd_en;
  logic              txd;
  logic              busy;
  logic              frame_done;

  modport master (
    input  tx_en, empty, fifo_data,
    output rd_en, txd, busy, frame_done
  );

  modport slave (
    output tx_en, empty, fifo_data,
    input  rd_en, txd, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops words from the byte FIFO and sends each as an async frame on txd.
// Optional even-parity bit after the data bits: define UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle high, waiting for tx_en & !empty
// POP    | rd_en strobe to the FIFO
// LOAD   | capture fifo_data into the shift register
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity of the data bits (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); frame_done on its last cycle
module fifo_uart_tx #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 16,
  parameter int DIV_W    = 8
) (
  input  logic           CLK,
  input  logic           RST,
  fifo_uart_tx_if.master bus
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] BAUD_LAST = DIV_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd6,
`endif
    STOP   = 3'd5
  } state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] shift_reg, shift_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic [DIV_W-1:0]  baud_cnt, baud_d;
  logic              txd_q, txd_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_wrap;
  logic              can_pop;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign can_pop   = bus.tx_en && !bus.empty;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      txd_q     <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      shift_reg <= shift_d;
      bit_cnt   <= bit_d;
      baud_cnt  <= baud_d;
      txd_q     <= txd_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_comb begin
    state_d = state;
    shift_d = shift_reg;
    bit_d   = bit_cnt;
    baud_d  = baud_cnt;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state)
      IDLE: if (can_pop) state_d = POP;
      POP:  state_d = LOAD;
      LOAD: begin
        shift_d = bus.fifo_data;
        bit_d   = '0;
        baud_d  = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^bus.fifo_data;
`endif
        state_d = START;
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_reg >> 1;
          bit_d   = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d = baud_cnt + DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_cnt + DIV_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = can_pop ? POP : IDLE;
        end else begin
          baud_d = baud_cnt + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
    rd_en_d = (state_d == POP);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  assign bus.txd        = txd_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
